// File: rtl/axis_decim_requant_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_decim_requant_if
//  Description : AXI-Stream bundle (tvalid/tready/tdata/tlast/tstrb) with
//                master and slave views.
//                master : drives tvalid/tdata/tlast/tstrb, samples tready
//                slave  : samples tvalid/tdata/tlast/tstrb, drives tready
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_decim_requant_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
    logic [DATA_W/8-1:0] tstrb;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tstrb,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tstrb,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_decim_requant.sv
`default_nettype none
// ============================================================================
//  Module      : axis_decim_requant
//  Description : Requantizes signed FIR accumulator samples to OUT_BITS with
//                round-half-up and signed saturation, keeps one sample in
//                every DECIM (tlast forces a keep and realigns the group),
//                and presents the result on a registered AXI-Stream master
//                with a two-entry (main + skid) output buffer.
//  Ports       : s00_axis_aclk   - clock for both streams
//                s00_axis_areset - asynchronous reset, active-high
//                s00_axis        - input stream (slave view), tstrb ignored
//                m00_axis        - output stream (master view)
//                sat_count       - saturating count of clamped kept samples
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_decim_requant #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int OUT_BITS               = 16,
    parameter int SHIFT                  = 7,
    parameter int DECIM                  = 4
) (
    input  wire                          s00_axis_aclk,
    input  wire                          s00_axis_areset,
    axis_decim_requant_if.slave          s00_axis,
    axis_decim_requant_if.master         m00_axis,
    output logic [15:0]                  sat_count
);
    localparam int IN_W  = C_S00_AXIS_TDATA_WIDTH;
    localparam int OUT_W = C_M00_AXIS_TDATA_WIDTH;
    // One guard bit so adding the rounding constant can never wrap.
    localparam int SUM_W = IN_W + 1;
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [SUM_W-1:0] c_RND =
        (SHIFT == 0) ? '0 : SUM_W'(64'd1 << ((SHIFT == 0) ? 0 : SHIFT - 1));
    localparam logic signed [SUM_W-1:0] c_MAX =
        SUM_W'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] c_MIN =
        SUM_W'(-(64'sd1 <<< (OUT_BITS - 1)));
    localparam logic [PH_W-1:0] c_PH_LAST = PH_W'(DECIM - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [PH_W-1:0]  r_phase;
    logic             r_s_ready;
    logic             r_m_valid;
    logic             r_m_last;
    logic [OUT_W-1:0] r_m_data;
    logic             r_k_valid;
    logic             r_k_last;
    logic [OUT_W-1:0] r_k_data;
    logic [15:0]      r_sat_cnt;

    // ------------------------------------------------------------------
    // Requantization datapath
    // ------------------------------------------------------------------
    logic signed [SUM_W-1:0] w_x;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shr;
    logic signed [SUM_W-1:0] w_clamped;
    logic                    w_sat;
    logic [OUT_W-1:0]        w_q;

    assign w_x   = SUM_W'($signed(s00_axis.tdata));
    assign w_sum = w_x + c_RND;
    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        w_clamped = w_shr;
        w_sat     = 1'b0;
        if (w_shr > c_MAX) begin
            w_clamped = c_MAX;
            w_sat     = 1'b1;
        end else if (w_shr < c_MIN) begin
            w_clamped = c_MIN;
            w_sat     = 1'b1;
        end
    end

    // The clamped value fits in OUT_BITS, so a signed resize is a plain
    // sign extension from OUT_BITS.
    assign w_q = OUT_W'(w_clamped);

    // ------------------------------------------------------------------
    // Handshake / buffer control
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_keep;
    logic w_m_drain;
    logic w_k_next;

    assign w_accept  = s00_axis.tvalid & r_s_ready;
    assign w_keep    = w_accept & ((r_phase == '0) | s00_axis.tlast);
    assign w_m_drain = r_m_valid & m00_axis.tready;

    // Skid entry is filled only by a keep while M is stalled; it empties as
    // soon as M drains. Accepts are impossible while it is full because
    // tready is low then, so the two cases never overlap.
    assign w_k_next = r_k_valid ? ~w_m_drain
                                : (w_keep & r_m_valid & ~w_m_drain);

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_phase   <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_k_valid <= 1'b0;
            r_k_last  <= 1'b0;
            r_k_data  <= '0;
            r_sat_cnt <= '0;
        end else begin
            if (w_accept) begin
                if (s00_axis.tlast || (r_phase == c_PH_LAST)) begin
                    r_phase <= '0;
                end else begin
                    r_phase <= r_phase + 1'b1;
                end
            end

            if (w_keep && w_sat && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end

            if (w_m_drain) begin
                if (r_k_valid) begin
                    r_m_data <= r_k_data;
                    r_m_last <= r_k_last;
                end else if (w_keep) begin
                    r_m_data <= w_q;
                    r_m_last <= s00_axis.tlast;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end else if (!r_m_valid) begin
                if (w_keep) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= w_q;
                    r_m_last  <= s00_axis.tlast;
                end
            end else if (w_keep) begin
                r_k_data <= w_q;
                r_k_last <= s00_axis.tlast;
            end

            r_k_valid <= w_k_next;
            r_s_ready <= ~w_k_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s00_axis.tready = r_s_ready;
    assign m00_axis.tvalid = r_m_valid;
    assign m00_axis.tdata  = r_m_data;
    assign m00_axis.tlast  = r_m_last;
    assign m00_axis.tstrb  = {(OUT_W/8){r_m_valid}};
    assign sat_count       = r_sat_cnt;

    // Input strobes carry no information for this block.
    logic w_unused_tstrb;
    assign w_unused_tstrb = &{1'b0, s00_axis.tstrb};

endmodule
`default_nettype wire
